biquad_cascade_scheduler: RTL and testbench
===========================================

Name: biquad_cascade_scheduler

Overview:
Sequences one shared, externally instantiated accumulating MAC across NUM_STAGES cascaded Direct Form I biquad sections, one audio sample at a time. Owns the coefficient bank, the per-signal history registers, output saturation, and the MAC control signals (clear, enable, operand mux). Sits between the I2S sample strobe and the output serializer; replaces per-band FSMs so that several EQ bands share one DSP slice.

Parameters:
NUM_STAGES, 3, number of cascaded biquad sections (1..8)
MAC_LATENCY, 1, clk cycles from an enabled mac_ce edge until mac_result includes that product
COEF_FRAC, 14, fractional bits of coefficients (Q2.14)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
sample_valid  in  1  one-cycle strobe; sample_in valid
sample_in  in  16  signed input sample x[n]
sample_out  out  16  signed filtered sample, held until next out_valid
out_valid  out  1  one-cycle strobe; sample_out updated
busy  out  1  high in every state except IDLE
overrun  out  1  one-cycle pulse: sample_valid arrived while busy
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NUM_STAGES*5)  index = stage*5 + {0:b0,1:b1,2:b2,3:a1,4:a2}
coef_wdata  in  16  signed Q2.14 coefficient
coef_commit  in  1  shadow-to-active copy request (COEF_SHADOW_EN only)
mac_clr  out  1  clear MAC accumulator
mac_ce  out  1  accumulate mac_a*mac_b
mac_a  out  16  coefficient operand
mac_b  out  16  data operand
mac_result  in  32  accumulator value

Behaviour:
- Reset: state IDLE; all outputs 0 except sample_out=0; histories and cur cleared; every stage b0=16384 (1.0), b1,b2,a1,a2=0 (passthrough).
- Storage: cur (stage input); hist[k].z1/z2 for k=0..NUM_STAGES (k=0 input signal, k=s+1 output of stage s).
- FSM: IDLE -> (sample_valid: cur<=sample_in, s<=0) CLEAR -> MAC -> DRAIN -> WB -> CLEAR (s<last, s++) | DONE (s==last) -> IDLE.
- CLEAR: mac_clr=1, 1 cycle. MAC: mac_ce=1, 5 cycles, term t=0..4: (b0,cur),(b1,hist[s].z1),(b2,hist[s].z2),(-a1,hist[s+1].z1),(-a2,hist[s+1].z2). DRAIN: MAC_LATENCY cycles, mac_ce=0. Outside MAC: mac_ce=0, mac_a=mac_b=0.
- Negation: -(-32768) saturates to +32767.
- WB: y = mac_result >>> COEF_FRAC (arithmetic, truncate), saturated to [-32768, 32767]; hist[s] <= {z1:cur, z2:hist[s].z1}; cur <= y; when s is last, also hist[NUM_STAGES] <= {y, hist[NUM_STAGES].z1}.
- DONE: sample_out <= cur, out_valid=1 for 1 cycle.
- Latency: out_valid high exactly 1 + NUM_STAGES*(7+MAC_LATENCY) cycles after the edge sampling sample_valid (25 at defaults).
- sample_valid while busy (including in DONE): sample dropped, overrun pulses, no state or history change.
- sample_valid in the same cycle as reset: reset wins.
- Reset mid-computation: abort immediately, no out_valid, all state reinitialised as at reset.
- Coefficient writes to addr >= NUM_STAGES*5 are ignored.

Optional Feature:
COEF_SHADOW_EN: defined -> coef_we writes a shadow bank; coef_commit sets a pending flag; shadow copies to the active bank in full on the IDLE->CLEAR transition only, so a sample never mixes old and new coefficients; commit while busy stays pending. Shadow resets to the same passthrough values. Undefined -> coef_we writes the active bank directly, takes effect on the next cycle even mid-sample, and coef_commit is ignored.

Decomposition:
- Package biquad_sched_pkg: state_t enum (IDLE, CLEAR, MAC, DRAIN, WB, DONE); term index enum B0..A2; COEF_UNITY=16'sd16384; function sat16(32-bit) and neg_sat16(16-bit).
- Sub-module coef_bank: active bank (plus shadow bank and commit logic under COEF_SHADOW_EN), with a combinational read port (stage, term).

Test Plan:
- Reset passthrough: inputs 1000, -32768, 32767 -> sample_out equal to the inputs; out_valid exactly 25 cycles after each sample_valid.
- Gain: stage0 b0=8192; input 2000 -> 1000; input -3 -> -2 (truncation toward -inf).
- Feedback: stage1 a1=-8192; impulse 16384 followed by zeros -> outputs 16384, 8192, 4096, 2048.
- Saturation: all stages b0=32767, input 30000 -> 32767; a1=-32768 negation path, no wrap.
- Overrun: sample_valid 10 cycles after the previous one -> overrun pulses once; exactly one out_valid; next sample output matches a golden model that excludes the dropped sample.
- COEF_SHADOW_EN: write b0=8192 plus coef_commit mid-sample -> current output is unity, next sample is halved; without the macro the same stimulus corrupts only the in-flight sample per the immediate-write rule.

Source files
------------

// File: rtl/biquad_sched_pkg.sv
// Shared types and arithmetic helpers for the biquad cascade scheduler.
// Saturating helpers keep Q2.14 products and results inside 16-bit range.
package biquad_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        DRAIN,
        WB,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        B0,
        B1,
        B2,
        A1,
        A2
    } term_t;

    localparam int TERMS = 5;
    localparam logic signed [15:0] COEF_UNITY = 16'sd16384;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7FFF;
        end
        if (x < -32'sd32768) begin
            return 16'sh8000;
        end
        return x[15:0];
    endfunction

    function automatic logic signed [15:0] neg_sat16(input logic signed [15:0] x);
        if (x == 16'sh8000) begin
            return 16'sh7FFF;
        end
        return -x;
    endfunction

    // Passthrough bank: b0 = 1.0 in every stage, all other taps zero.
    function automatic logic signed [15:0] coef_init(input int idx);
        return ((idx % TERMS) == 0) ? COEF_UNITY : 16'sd0;
    endfunction

endpackage

// File: rtl/biquad_cascade_scheduler_coef_bank.sv
// Biquad coefficient storage with a combinational (stage, term) read port.
// COEF_SHADOW_EN adds a shadow bank copied in full when a sample starts.
module coef_bank
    import biquad_sched_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int AW = 4,
    parameter int SW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic signed [15:0] wdata,
    input  logic               commit,
    input  logic               load,
    input  logic [SW-1:0]      rd_stage,
    input  term_t              rd_term,
    output logic signed [15:0] rd_data
);

    localparam int DEPTH = NUM_STAGES * TERMS;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic signed [15:0] act_q [DEPTH];
    logic signed [15:0] act_d [DEPTH];
    logic               wr_ok;
    logic [AW-1:0]      rd_idx;

    assign wr_ok   = we && ({1'b0, addr} < DEPTH_W);
    assign rd_idx  = AW'(32'(rd_stage) * 32'd5 + 32'(rd_term));
    assign rd_data = act_q[rd_idx];

`ifdef COEF_SHADOW_EN
    logic signed [15:0] shd_q [DEPTH];
    logic signed [15:0] shd_d [DEPTH];
    logic               pend_q;
    logic               pend_d;

    always_comb begin
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        if (wr_ok) begin
            shd_d[addr] = wdata;
        end
        // Copy only at sample start so a sample never sees mixed banks.
        if (load && pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (commit) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                shd_q[i] <= coef_init(i);
            end
            pend_q <= 1'b0;
        end else begin
            shd_q  <= shd_d;
            pend_q <= pend_d;
        end
    end
`else
    logic unused_ctl;
    assign unused_ctl = commit ^ load;

    always_comb begin
        act_d = act_q;
        if (wr_ok) begin
            act_d[addr] = wdata;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                act_q[i] <= coef_init(i);
            end
        end else begin
            act_q <= act_d;
        end
    end

endmodule

// File: rtl/biquad_cascade_scheduler.sv
// Time-multiplexes one external MAC over a cascade of DF-I biquad sections.
// Define COEF_SHADOW_EN for shadowed, commit-on-sample-start coefficients.
module biquad_cascade_scheduler
    import biquad_sched_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int MAC_LATENCY = 1,
    parameter int COEF_FRAC   = 14
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sample_valid,
    input  logic signed [15:0]                   sample_in,
    output logic signed [15:0]                   sample_out,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic                                 overrun,
    input  logic                                 coef_we,
    input  logic [$clog2(NUM_STAGES*TERMS)-1:0]  coef_addr,
    input  logic signed [15:0]                   coef_wdata,
    input  logic                                 coef_commit,
    output logic                                 mac_clr,
    output logic                                 mac_ce,
    output logic signed [15:0]                   mac_a,
    output logic signed [15:0]                   mac_b,
    input  logic [31:0]                          mac_result
);

    localparam int AW = $clog2(NUM_STAGES * TERMS);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int HW = $clog2(NUM_STAGES + 1);
    localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LATENCY - 1);

    state_t             state_q, state_d;
    term_t              term_q, term_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic signed [15:0] cur_q, cur_d;
    logic signed [15:0] z1_q [NUM_STAGES+1];
    logic signed [15:0] z1_d [NUM_STAGES+1];
    logic signed [15:0] z2_q [NUM_STAGES+1];
    logic signed [15:0] z2_d [NUM_STAGES+1];
    logic signed [15:0] sample_out_q, sample_out_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic               load;
    logic signed [15:0] coef;
    logic signed [15:0] y;
    logic [HW-1:0]      hs;
    logic [HW-1:0]      hs1;

    assign hs  = HW'(stage_q);
    assign hs1 = hs + HW'(1);
    assign y   = sat16($signed(mac_result) >>> COEF_FRAC);

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

    coef_bank #(
        .NUM_STAGES (NUM_STAGES),
        .AW         (AW),
        .SW         (SW)
    ) u_coef_bank (
        .clk      (clk),
        .reset    (reset),
        .we       (coef_we),
        .addr     (coef_addr),
        .wdata    (coef_wdata),
        .commit   (coef_commit),
        .load     (load),
        .rd_stage (stage_q),
        .rd_term  (term_q),
        .rd_data  (coef)
    );

    always_comb begin
        state_d      = state_q;
        term_d       = term_q;
        stage_d      = stage_q;
        drain_d      = drain_q;
        cur_d        = cur_q;
        z1_d         = z1_q;
        z2_d         = z2_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = sample_valid && (state_q != IDLE);
        load         = 1'b0;
        mac_clr      = 1'b0;
        mac_ce       = 1'b0;
        mac_a        = '0;
        mac_b        = '0;
        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    load    = 1'b1;
                    cur_d   = sample_in;
                    stage_d = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                term_d  = B0;
                state_d = MAC;
            end
            MAC: begin
                mac_ce = 1'b1;
                mac_a  = coef;
                unique case (term_q)
                    B0: mac_b = cur_q;
                    B1: mac_b = z1_q[hs];
                    B2: mac_b = z2_q[hs];
                    A1: begin
                        mac_a = neg_sat16(coef);
                        mac_b = z1_q[hs1];
                    end
                    A2: begin
                        mac_a = neg_sat16(coef);
                        mac_b = z2_q[hs1];
                    end
                    default: mac_b = '0;
                endcase
                if (term_q == A2) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    term_d = term_t'(term_q + 3'd1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = WB;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            WB: begin
                z1_d[hs] = cur_q;
                z2_d[hs] = z1_q[hs];
                cur_d    = y;
                if (stage_q == LAST) begin
                    z1_d[NUM_STAGES] = y;
                    z2_d[NUM_STAGES] = z1_q[NUM_STAGES];
                    state_d          = DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                    state_d = CLEAR;
                end
            end
            DONE: begin
                sample_out_d = cur_q;
                out_valid_d  = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            term_q       <= B0;
            stage_q      <= '0;
            drain_q      <= '0;
            cur_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k <= NUM_STAGES; k++) begin
                z1_q[k] <= '0;
                z2_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            term_q       <= term_d;
            stage_q      <= stage_d;
            drain_q      <= drain_d;
            cur_q        <= cur_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            z1_q         <= z1_d;
            z2_q         <= z2_d;
        end
    end

endmodule

// File: tb/tb_biquad_cascade_scheduler.sv
// Bench for biquad_cascade_scheduler: behavioural DF-I cascade model plus MAC.
// Honours COEF_SHADOW_EN the same way as the design build.
module tb_biquad_cascade_scheduler;

    localparam int NS    = 3;
    localparam int ML    = 1;
    localparam int DEPTH = NS * 5;
    localparam int LAT   = 1 + NS * (7 + ML);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic               busy;
    logic               overrun;
    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               coef_commit = 1'b0;
    logic               mac_clr;
    logic               mac_ce;
    logic signed [15:0] mac_a;
    logic signed [15:0] mac_b;
    logic signed [31:0] acc = '0;

    always #5 clk = ~clk;

    biquad_cascade_scheduler #(
        .NUM_STAGES  (NS),
        .MAC_LATENCY (ML),
        .COEF_FRAC   (14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .coef_commit  (coef_commit),
        .mac_clr      (mac_clr),
        .mac_ce       (mac_ce),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_result   (acc)
    );

    // External single-cycle accumulating MAC.
    always @(posedge clk) begin
        if (mac_clr) acc <= '0;
        else if (mac_ce) acc <= acc + mac_a * mac_b;
    end

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_ov = 0;
    int n_orun = 0;
    bit sv_acc = 1'b0;
    int m_act [DEPTH];
    int m_shd [DEPTH];
    bit m_pend;
    int m_z1 [NS+1];
    int m_z2 [NS+1];
    int q_in [$];
    int outs [$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nsat(input int a);
        return (a == -32768) ? 32767 : -a;
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_act[i] = ((i % 5) == 0) ? 16384 : 0;
            m_shd[i] = m_act[i];
        end
        for (int k = 0; k <= NS; k++) begin
            m_z1[k] = 0;
            m_z2[k] = 0;
        end
        m_pend = 1'b0;
        q_in.delete();
    endfunction

    // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 in a 32-bit accumulator.
    function automatic int model_step(input int x);
        int     sig;
        int     y;
        int     c [5];
        longint s;
        sig = x;
        for (int st = 0; st < NS; st++) begin
            for (int t = 0; t < 5; t++) c[t] = m_act[st*5+t];
            s = longint'(c[0]) * sig
              + longint'(c[1]) * m_z1[st]
              + longint'(c[2]) * m_z2[st]
              + longint'(nsat(c[3])) * m_z1[st+1]
              + longint'(nsat(c[4])) * m_z2[st+1];
            y = clamp(int'(s) >>> 14);
            m_z2[st] = m_z1[st];
            m_z1[st] = sig;
            sig = y;
        end
        m_z2[NS] = m_z1[NS];
        m_z1[NS] = sig;
        return sig;
    endfunction

    always @(negedge clk) begin
        int x;
        int e;
        cyc++;
        if (sample_valid && sv_acc) acc_cyc = cyc;
        if (overrun) n_orun++;
        if (out_valid) begin
            n_ov++;
            outs.push_back(int'(sample_out));
            if (q_in.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                x = q_in.pop_front();
                e = model_step(x);
                check("sample_out", int'(sample_out), e);
                check("latency", cyc - acc_cyc - 1, LAT);
            end
        end
    end

    task automatic pulse(input int x, input bit accept);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_in    = 16'(x);
        sv_acc       = accept;
        if (accept) begin
            q_in.push_back(x);
`ifdef COEF_SHADOW_EN
            if (m_pend) begin
                m_act  = m_shd;
                m_pend = 1'b0;
            end
`endif
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sv_acc       = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int v);
        @(posedge clk);
        #1;
        coef_we    = 1'b1;
        coef_addr  = 4'(addr);
        coef_wdata = 16'(v);
        if (addr < DEPTH) begin
`ifdef COEF_SHADOW_EN
            m_shd[addr] = v;
`else
            m_act[addr] = v;
`endif
        end
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        coef_commit = 1'b1;
`ifdef COEF_SHADOW_EN
        m_pend = 1'b1;
`endif
        @(posedge clk);
        #1;
        coef_commit = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && q_in.size() != 0; i++) @(posedge clk);
        if (q_in.size() != 0) begin
            check("timeout", q_in.size(), 0);
            q_in.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        int or0;
        int v;
        int pass_in [3];
        pass_in = '{1000, -32768, 32767};
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_mac_clr", int'(mac_clr), 0);
        check("rst_mac_ce", int'(mac_ce), 0);
        check("rst_mac_a", int'(mac_a), 0);
        check("rst_mac_b", int'(mac_b), 0);
        #1 reset = 1'b0;

        outs.delete();
        foreach (pass_in[i]) begin
            pulse(pass_in[i], 1'b1);
            wait_done();
        end
        for (int i = 0; i < 3; i++) check("passthru", outs[i], pass_in[i]);

        outs.delete();
        wr_coef(0, 8192);
        commit();
        pulse(2000, 1'b1);
        wait_done();
        pulse(-3, 1'b1);
        wait_done();
        check("gain_half", outs[0], 1000);
        check("gain_trunc", outs[1], -2);

        do_reset();
        outs.delete();
        wr_coef(8, -8192);
        commit();
        pulse(16384, 1'b1);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            pulse(0, 1'b1);
            wait_done();
        end
        check("fb0", outs[0], 16384);
        check("fb1", outs[1], 8192);
        check("fb2", outs[2], 4096);
        check("fb3", outs[3], 2048);

        do_reset();
        outs.delete();
        for (int s = 0; s < NS; s++) wr_coef(s * 5, 32767);
        commit();
        pulse(30000, 1'b1);
        wait_done();
        check("sat_pos", outs[0], 32767);
        wr_coef(3, -32768);
        commit();
        pulse(30000, 1'b1);
        wait_done();
        pulse(-30000, 1'b1);
        wait_done();
        pulse(12345, 1'b1);
        wait_done();

        do_reset();
        ov0 = n_ov;
        or0 = n_orun;
        pulse(1111, 1'b1);
        repeat (8) @(posedge clk);
        pulse(2222, 1'b0);
        wait_done();
        check("overrun_busy", n_orun - or0, 1);
        check("overrun_outs", n_ov - ov0, 1);
        pulse(3333, 1'b1);
        wait_done();
        pulse(4444, 1'b1);
        repeat (23) @(posedge clk);
        pulse(5555, 1'b0);
        wait_done();
        check("overrun_done", n_orun - or0, 2);
        pulse(6666, 1'b1);
        wait_done();
        check("overrun_total_outs", n_ov - ov0, 4);

        ov0 = n_ov;
        pulse(7777, 1'b1);
        repeat (10) @(posedge clk);
        do_reset();
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("abort_no_out", n_ov - ov0, 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sample_out", int'(sample_out), 0);

        @(posedge clk);
        #1;
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'sd999;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_wins_busy", int'(busy), 0);
        repeat (40) @(posedge clk);
        check("rst_wins_no_out", n_ov - ov0, 0);

        do_reset();
        outs.delete();
        pulse(8000, 1'b1);
        repeat (8) @(posedge clk);
        wr_coef(10, 8192);
        commit();
        wait_done();
        pulse(8000, 1'b1);
        wait_done();
`ifdef COEF_SHADOW_EN
        check("shadow_inflight", outs[0], 8000);
`else
        check("direct_inflight", outs[0], 4000);
`endif
        check("commit_next", outs[1], 4000);

        do_reset();
        for (int a = 0; a < DEPTH; a++) begin
            if ((a % 5) < 3) v = int'($urandom_range(0, 32767)) - 16384;
            else v = int'($urandom_range(0, 16383)) - 8192;
            wr_coef(a, v);
        end
        wr_coef(15, 1234);
        commit();
        for (int i = 0; i < 30; i++) begin
            pulse(int'($urandom_range(0, 65535)) - 32768, 1'b1);
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
